// File: rtl/fifo_stream_reader.sv
// Read-side controller for the 16x8 synchronous FIFO: drains it through rd/empty/dout,
// absorbs the one-cycle read latency in a 3-entry buffer and presents a valid/ready stream.
module fifo_stream_reader #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          fifo_empty,
    input  logic          fifo_wr_acc,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_rd,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [CW-1:0] word_cnt,
    output logic          busy
);

    logic [DW-1:0] mem_q [3];
    logic [DW-1:0] mem_d [3];
    logic [1:0]    head_q, head_d;
    logic [1:0]    tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0]    load_w;
    logic          rd_acc;
    logic          pop;
    logic          capture;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = mem_q[head_q];
    assign word_cnt = cnt_q;
    assign busy     = (occ_q != 2'd0) || inflight_q;

    always_comb begin
        // Room is reserved for the in-flight word, so a read never outruns the buffer.
        load_w  = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_rd = !rst && !fifo_empty && !flush && (load_w <= 3'd2);
        rd_acc  = fifo_rd && !fifo_wr_acc;
        pop     = m_valid && m_ready && !flush;
        capture = inflight_q && !flush;

        mem_d      = mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        cnt_d      = cnt_q;

        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
            inflight_d = 1'b0;
        end else begin
            inflight_d = rd_acc;
            if (capture) begin
                mem_d[tail_q] = fifo_dout;
                tail_d        = inc3(tail_q);
            end
            if (pop) begin
                head_d = inc3(head_q);
                cnt_d  = cnt_q + CW'(1);
            end
            unique case ({capture, pop})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
